display_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit common-anode 7-segment display that shows AES results on the board.
- Holds a 16-bit display word plus a display mode, and drives one digit at a time. For each digit it selects the 5-bit alphanumeric code that goes to the cathode decoder and generates the active-low anode enables.
- Updates are double-buffered and take effect only at a frame boundary, so the display never tears. A guard interval blanks all anodes at each digit change to suppress ghosting.

---
 rtl/disp_pkg.sv | 25 ++
 rtl/scan_timer.sv | 59 +++++
 rtl/display_scan_ctrl.sv | 118 +++++++++++
 tb/tb_display_scan_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants for the 7-segment scan controller.
//               Alphanumeric codes understood by the cathode decoder and the
//               display mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Codes above 15 are letters and symbols; 0..15 are plain hex digits.
    localparam logic [4:0] CODE_P    = 5'd16;
    localparam logic [4:0] CODE_DASH = 5'd17;
    localparam logic [4:0] CODE_A    = 5'd10;
    localparam logic [4:0] CODE_S    = 5'd5;

    typedef enum logic [1:0] {
        MODE_HEX   = 2'b00,
        MODE_DASH  = 2'b01,
        MODE_PASS  = 2'b10,
        MODE_BLANK = 2'b11
    } mode_e;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : Digit-slot timebase. Counts REFRESH_DIV cycles per slot,
//               steps the digit index 0..3, flags the frame boundary (last
//               cycle of digit 3) and emits a registered frame tick that is
//               high in the first cycle of the new frame.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               o_div_cnt         - position inside the current slot
//               o_digit           - current digit slot
//               o_boundary        - combinational, last cycle of the frame
//               o_frame_tick      - one-cycle pulse after the boundary edge
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_div_cnt,
    output logic [1:0]       o_digit,
    output logic             o_boundary,
    output logic             o_frame_tick
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic [1:0]       r_digit;
    logic             r_frame_tick;
    logic             w_wrap;

    // Exact-equality wrap so non-power-of-two dividers work unchanged.
    assign w_wrap     = (r_div_cnt == c_last_cnt);
    assign o_boundary = w_wrap && (r_digit == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_digit      <= 2'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= o_boundary;
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_digit   <= r_digit + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + CNT_W'(1);
            end
        end
    end

    assign o_div_cnt    = r_div_cnt;
    assign o_digit      = r_digit;
    assign o_frame_tick = r_frame_tick;

endmodule : scan_timer
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit common-anode
//               7-segment display. New content is accepted into a pending
//               buffer and copied into the shadow (displayed) buffer only at
//               a frame boundary, so a frame is never torn. All anodes are
//               blanked for GUARD cycles at the start of every slot.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               load              - one-cycle request to accept new content
//               data_in, mode_in  - display word and mode
//               ready             - a load will be accepted this cycle
//               alphan            - code to the cathode decoder
//               an                - anode enables, active-low
//               digit_sel         - current digit slot
//               frame_tick        - one-cycle pulse at frame start
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [1:0]  mode_in,
    output logic        ready,
    output logic [4:0]  alphan,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] w_div_cnt;
    logic [1:0]       w_digit;
    logic             w_boundary;
    logic             w_in_guard;
    logic [15:0]      w_shifted;

    logic [15:0]      r_pending_data;
    mode_e            r_pending_mode;
    logic             r_pending_valid;
    logic [15:0]      r_shadow_data;
    mode_e            r_shadow_mode;

    scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_scan_timer (
        .clk          (clk),
        .rst          (reset),
        .o_div_cnt    (w_div_cnt),
        .o_digit      (w_digit),
        .o_boundary   (w_boundary),
        .o_frame_tick (frame_tick)
    );

    // The buffer accepts a new word only when empty; a load arriving in the
    // boundary cycle lands in pending and waits for the next boundary,
    // because the transfer below looks at the pre-edge pending_valid.
    assign ready = !r_pending_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending_data  <= 16'h0000;
            r_pending_mode  <= MODE_DASH;
            r_pending_valid <= 1'b0;
            r_shadow_data   <= 16'h0000;
            r_shadow_mode   <= MODE_DASH;
        end else begin
            if (w_boundary && r_pending_valid) begin
                r_shadow_data   <= r_pending_data;
                r_shadow_mode   <= r_pending_mode;
                r_pending_valid <= 1'b0;
            end
            if (load && ready) begin
                r_pending_data  <= data_in;
                r_pending_mode  <= mode_e'(mode_in);
                r_pending_valid <= 1'b1;
            end
        end
    end

    assign digit_sel  = w_digit;
    assign w_in_guard = (int'(w_div_cnt) < GUARD);
    assign w_shifted  = r_shadow_data >> {w_digit, 2'b00};

    always_comb begin
        an = 4'b1111;
        if (!w_in_guard && (r_shadow_mode != MODE_BLANK)) begin
            an = ~(4'b0001 << w_digit);
        end
    end

    always_comb begin
        alphan = CODE_DASH;
        case (r_shadow_mode)
            MODE_HEX:  alphan = {1'b0, w_shifted[3:0]};
            MODE_PASS: begin
                case (w_digit)
                    2'd3:    alphan = CODE_P;
                    2'd2:    alphan = CODE_A;
                    default: alphan = CODE_S;
                endcase
            end
            // Blank keeps a fixed code so the outputs stay deterministic
            // even though no anode is lit.
            default:   alphan = CODE_DASH;
        endcase
    end

endmodule : display_scan_ctrl
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Scoreboard bench for display_scan_ctrl (REFRESH_DIV=8,
//               GUARD=2). A driver applies stimulus, advances a cycle-count
//               reference model and queues the expected outputs; a monitor
//               on the falling edge pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int R = 8;
    localparam int G = 2;
    localparam int F = 4 * R;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data_in;
    logic [1:0]  mode_in;
    logic        ready;
    logic [4:0]  alphan;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .REFRESH_DIV (R),
        .GUARD       (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .mode_in    (mode_in),
        .ready      (ready),
        .alphan     (alphan),
        .an         (an),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [4:0] alphan;
        logic [1:0] dsel;
        logic       ready;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   started = 0;

    // Reference model: time since reset plus the two content buffers.
    int          t;
    bit          pv;
    logic [15:0] pdata, sdata;
    logic [1:0]  pmode, smode;
    bit          tick;

    function automatic exp_t expect_now();
        exp_t e;
        int digit;
        int pos;
        digit = (t / R) % 4;
        pos   = t % R;
        case (smode)
            2'd0:    e.alphan = 5'((sdata >> (4 * digit)) & 16'hF);
            2'd2:    e.alphan = (digit == 3) ? 5'd16 : (digit == 2) ? 5'd10 : 5'd5;
            default: e.alphan = 5'd17;
        endcase
        e.an    = (pos < G || smode == 2'd3) ? 4'hF : (4'hF ^ (4'h1 << digit));
        e.dsel  = 2'(digit);
        e.ready = !pv;
        e.tick  = tick;
        return e;
    endfunction

    task automatic step(input bit rst_i, input bit ld, input logic [15:0] d,
                        input logic [1:0] m);
        reset   = rst_i;
        load    = ld;
        data_in = d;
        mode_in = m;
        @(posedge clk);
        #1;
        if (rst_i) begin
            t = 0; pv = 0; smode = 2'd1; sdata = 16'h0; tick = 0;
        end else begin
            bit bnd;
            bit rdy;
            bnd = ((t % F) == F - 1);
            rdy = !pv;
            if (bnd && pv) begin
                sdata = pdata; smode = pmode; pv = 0;
            end
            if (ld && rdy) begin
                pdata = d; pmode = m; pv = 1;
            end
            tick = bnd;
            t++;
        end
        q.push_back(expect_now());
        started = 1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'($urandom), 2'($urandom));
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (got no match, required condition)", name);
    endtask

    // Monitor: one expected entry per cycle once the driver has started.
    always @(negedge clk) begin
        if (started) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: actual=no expectation queued, required=one per cycle");
            end else begin
                exp_t e;
                exp_t a;
                e = q.pop_front();
                a = '{an: an, alphan: alphan, dsel: digit_sel, ready: ready, tick: frame_tick};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: actual an=%b alphan=%0d dsel=%0d ready=%b tick=%b required an=%b alphan=%0d dsel=%0d ready=%b tick=%b",
                             $time, a.an, a.alphan, a.dsel, a.ready, a.tick,
                             e.an, e.alphan, e.dsel, e.ready, e.tick);
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; load = 1'b0; data_in = 16'h0; mode_in = 2'd0;
        t = 0; pv = 0; pdata = 16'h0; sdata = 16'h0; pmode = 2'd1; smode = 2'd1; tick = 0;

        // Reset and free-running dashes.
        step(1'b1, 1'b0, 16'h0, 2'd0);
        step(1'b1, 1'b1, 16'hFFFF, 2'd0);
        repeat (40) idle();

        // Hex load mid-frame, then a load while busy that must be dropped.
        repeat ($urandom_range(3, 12)) idle();
        step(1'b0, 1'b1, 16'h3A7F, 2'd0);
        repeat (3) idle();
        step(1'b0, 1'b1, 16'h1111, 2'd0);
        repeat (80) idle();

        // Load exactly in the boundary cycle: must wait one more frame.
        n = 0;
        while (!(((t % F) == F - 1) && !pv) && n < 200) begin idle(); n++; end
        if (n >= 200) timeout("boundary_wait");
        step(1'b0, 1'b1, 16'($urandom), 2'd2);
        repeat (80) idle();

        // Blank mode.
        n = 0;
        while (pv && n < 200) begin idle(); n++; end
        step(1'b0, 1'b1, 16'($urandom), 2'd3);
        repeat (80) idle();

        // Reset at digit 2 with a load pending.
        n = 0;
        while (!((t % F) == 0 && !pv) && n < 200) begin idle(); n++; end
        if (n >= 200) timeout("frame_start_wait");
        step(1'b0, 1'b1, 16'hBEEF, 2'd0);
        n = 0;
        while (((t / R) % 4) != 2 && n < 200) begin idle(); n++; end
        if (n >= 200) timeout("digit2_wait");
        step(1'b1, 1'b0, 16'h0, 2'd0);
        repeat (50) idle();

        // Randomized traffic with occasional resets.
        repeat (800) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), 2'($urandom));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=simulation still running, required=finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_display_scan_ctrl
`default_nettype wire
